// File: rtl/fill_pkg.sv
// Shared types and constants for the bottling-lane fill sequencer.
package fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_BOTTLE,
        DISPENSE,
        WAIT_PILL,
        ADVANCE,
        DONE,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CFG  = 2'd1,
        ERR_JAM  = 2'd2,
        ERR_LOST = 2'd3
    } err_t;

    localparam int MAX_PER_BOTTLE = 20;

    function automatic logic cfg_ok(input logic [4:0] per, input logic [9:0] batch);
        return (per != 5'd0) && (per <= 5'(MAX_PER_BOTTLE)) && (batch != 10'd0);
    endfunction

endpackage

// File: rtl/fill_sequencer_tick_timer.sv
// Tick-enabled down-counter; expired is high while the count sits at zero.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         tick,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (clear)
                cnt_d = '0;
            else if (load)
                cnt_d = load_val;
            else if (cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fill_sequencer.sv
// One bottling lane: configure, wait for a bottle, dispense and confirm each pill,
// advance the conveyor, and count bottles until the batch is complete.
module fill_sequencer
    import fill_pkg::*;
#(
    parameter int PILL_TIMEOUT = 8,
    parameter int ADV_TICKS    = 3
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic [4:0]  cfg_per_bottle,
    input  logic [9:0]  cfg_batch,
    input  logic        bottle_present,
    input  logic        pill_seen,
    output logic        dispense,
    output logic        conveyor_adv,
    output logic [4:0]  one_cnt,
    output logic [9:0]  all_cnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2((PILL_TIMEOUT > ADV_TICKS) ? PILL_TIMEOUT : ADV_TICKS) + 1;

    state_t      state_q, state_d;
    err_t        err_q, err_d;
    logic [4:0]  one_q, one_d, per_q, per_d;
    logic [9:0]  all_q, all_d, batch_q, batch_d;
    logic        dispense_q, dispense_d;
    logic        conv_q, conv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val;

    // The single timer serves WAIT_PILL and ADVANCE; it is reloaded on entry to each.
    tick_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .rst      (rst),
        .tick     (tick),
        .clear    (stop),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        one_d    = one_q;
        all_d    = all_q;
        per_d    = per_q;
        batch_d  = batch_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (tick) begin
            if (stop) begin
                state_d = IDLE;
                err_d   = ERR_NONE;
            end else begin
                unique case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_d = CHECK;
                            one_d   = '0;
                            all_d   = '0;
                        end
                    end
                    CHECK: begin
                        per_d   = cfg_per_bottle;
                        batch_d = cfg_batch;
                        if (!cfg_ok(cfg_per_bottle, cfg_batch)) begin
                            state_d = FAULT;
                            err_d   = ERR_CFG;
                        end else begin
                            state_d = WAIT_BOTTLE;
                        end
                    end
                    WAIT_BOTTLE: begin
                        if (bottle_present)
                            state_d = DISPENSE;
                    end
                    DISPENSE: begin
                        state_d  = WAIT_PILL;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(PILL_TIMEOUT - 1);
                    end
                    WAIT_PILL: begin
                        // A pill confirmed on the timeout tick still counts.
                        if (!bottle_present) begin
                            state_d = FAULT;
                            err_d   = ERR_LOST;
                        end else if (pill_seen) begin
                            one_d = one_q + 5'd1;
                            if (one_d == per_q) begin
                                all_d    = all_q + 10'd1;
                                state_d  = ADVANCE;
                                tmr_load = 1'b1;
                                tmr_val  = TW'(ADV_TICKS - 1);
                            end else begin
                                state_d = DISPENSE;
                            end
                        end else if (tmr_expired) begin
                            state_d = FAULT;
                            err_d   = ERR_JAM;
                        end
                    end
                    ADVANCE: begin
                        if (tmr_expired) begin
                            if (all_q == batch_q) begin
                                state_d = DONE;
                            end else begin
                                one_d   = '0;
                                state_d = WAIT_BOTTLE;
                            end
                        end
                    end
                    FAULT: ;
                    default: state_d = IDLE;
                endcase
            end
        end

        dispense_d = (state_d == DISPENSE);
        conv_d     = (state_d == ADVANCE);
        done_d     = (state_d == DONE);
        busy_d     = !(state_d inside {IDLE, DONE, FAULT});
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            one_q      <= '0;
            all_q      <= '0;
            per_q      <= '0;
            batch_q    <= '0;
            dispense_q <= 1'b0;
            conv_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            one_q      <= one_d;
            all_q      <= all_d;
            per_q      <= per_d;
            batch_q    <= batch_d;
            dispense_q <= dispense_d;
            conv_q     <= conv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dispense     = dispense_q;
    assign conveyor_adv = conv_q;
    assign one_cnt      = one_q;
    assign all_cnt      = all_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_code     = err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer: tick every 4 clocks, drop sensor answers one tick after dispense.
module tb_fill_sequencer;

    logic        clock;
    logic        rst;
    logic        tick;
    logic        start;
    logic        stop;
    logic [4:0]  cfg_per_bottle;
    logic [9:0]  cfg_batch;
    logic        bottle_present;
    logic        pill_seen;
    logic        dispense;
    logic        conveyor_adv;
    logic [4:0]  one_cnt;
    logic [9:0]  all_cnt;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    bit sensor_en = 1'b0;
    bit pend      = 1'b0;

    fill_sequencer dut (
        .clock          (clock),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .stop           (stop),
        .cfg_per_bottle (cfg_per_bottle),
        .cfg_batch      (cfg_batch),
        .bottle_present (bottle_present),
        .pill_seen      (pill_seen),
        .dispense       (dispense),
        .conveyor_adv   (conveyor_adv),
        .one_cnt        (one_cnt),
        .all_cnt        (all_cnt),
        .busy           (busy),
        .done           (done),
        .err_code       (err_code)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clock);
            phase = (phase + 1) % 4;
            tick  = (phase == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to the negedge after the next clock edge on which tick was high.
    task automatic next_tick();
        do @(posedge clock); while (tick !== 1'b1);
        @(negedge clock);
    endtask

    // One tick with the drop-sensor model: pill_seen rises one tick after a dispense pulse.
    task automatic sense_tick();
        next_tick();
        pill_seen = pend;
        pend      = sensor_en && dispense;
    endtask

    task automatic run_to_done(input int budget, output bit hit, output int n_disp,
                               output int n_conv, output int n_win);
        logic prev_conv;
        hit = 1'b0; n_disp = 0; n_conv = 0; n_win = 0;
        for (int i = 0; i < budget; i++) begin
            prev_conv = conveyor_adv;
            sense_tick();
            if (dispense) n_disp++;
            if (conveyor_adv) n_conv++;
            if (conveyor_adv && !prev_conv) n_win++;
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic kick_start();
        start = 1'b1;
        next_tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        sensor_en = 1'b0; pend = 1'b0; pill_seen = 1'b0;
        next_tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; bottle_present = 1'b0; pill_seen = 1'b0;
        cfg_per_bottle = '0; cfg_batch = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({dispense, conveyor_adv, busy, done, err_code, one_cnt, all_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {dispense, conveyor_adv, busy, done, err_code, one_cnt, all_cnt});
        end
        rst = 1'b0;
        next_tick();
        checks++;
        if ({busy, done, dispense} !== 3'b000) begin
            errors++;
            $display("FAIL idle_without_start: got %b expected 000", {busy, done, dispense});
        end
    endtask

    task automatic test_normal_batch();
        bit hit; int nd, nc, nw;
        cfg_per_bottle = 5'd3; cfg_batch = 10'd2; bottle_present = 1'b1;
        sensor_en = 1'b1; pend = 1'b0; pill_seen = 1'b0;
        kick_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL check_busy: got %b expected 1", busy);
        end
        next_tick();
        // Changing cfg after CHECK must have no effect.
        cfg_per_bottle = 5'd7; cfg_batch = 10'd9;
        run_to_done(100, hit, nd, nc, nw);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL batch_done_timeout: done never seen within 100 ticks");
        end
        checks++;
        if (nd !== 6) begin
            errors++;
            $display("FAIL dispense_pulses: got %0d expected 6", nd);
        end
        checks++;
        if (nc !== 6 || nw !== 2) begin
            errors++;
            $display("FAIL conveyor_windows: got %0d ticks in %0d windows expected 6 in 2", nc, nw);
        end
        checks++;
        if ({done, busy, all_cnt, one_cnt} !== {1'b1, 1'b0, 10'd2, 5'd3}) begin
            errors++;
            $display("FAIL batch_final: got done=%b busy=%b all=%0d one=%0d expected 1 0 2 3",
                     done, busy, all_cnt, one_cnt);
        end
        sensor_en = 1'b0; pend = 1'b0; pill_seen = 1'b0;
    endtask

    task automatic test_cfg_fault();
        logic [4:0] pers [3];
        logic [9:0] bats [3];
        pers[0] = 5'd0;  bats[0] = 10'd4;
        pers[1] = 5'd21; bats[1] = 10'd4;
        pers[2] = 5'd5;  bats[2] = 10'd0;
        for (int i = 0; i < 3; i++) begin
            cfg_per_bottle = pers[i]; cfg_batch = bats[i];
            kick_start();
            next_tick();
            checks++;
            if ({err_code, dispense, busy, conveyor_adv} !== {2'd1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL cfg_fault_%0d: got err=%0d disp=%b busy=%b expected err=1 0 0",
                         i, err_code, dispense, busy);
            end
            start = 1'b1;
            next_tick();
            start = 1'b0;
            checks++;
            if ({err_code, dispense, busy} !== {2'd1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL fault_ignores_start_%0d: got err=%0d disp=%b busy=%b expected 1 0 0",
                         i, err_code, dispense, busy);
            end
            do_stop();
            checks++;
            if ({err_code, busy} !== 3'b000) begin
                errors++;
                $display("FAIL stop_clears_err_%0d: got err=%0d busy=%b expected 0 0", i, err_code, busy);
            end
        end
    endtask

    task automatic test_jam();
        cfg_per_bottle = 5'd2; cfg_batch = 10'd1; bottle_present = 1'b1; pill_seen = 1'b0;
        kick_start();
        next_tick();
        next_tick();
        checks++;
        if (dispense !== 1'b1) begin
            errors++;
            $display("FAIL jam_first_dispense: got %b expected 1", dispense);
        end
        next_tick();
        for (int i = 1; i <= 7; i++) next_tick();
        checks++;
        if ({err_code, busy} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL jam_not_before_8: got err=%0d busy=%b expected 0 1", err_code, busy);
        end
        next_tick();
        checks++;
        if ({err_code, one_cnt, busy} !== {2'd2, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL jam_fault: got err=%0d one=%0d busy=%b expected 2 0 0", err_code, one_cnt, busy);
        end
        do_stop();
    endtask

    task automatic test_bottle_lost();
        bit hit;
        cfg_per_bottle = 5'd5; cfg_batch = 10'd1; bottle_present = 1'b1;
        sensor_en = 1'b1; pend = 1'b0; pill_seen = 1'b0;
        kick_start();
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sense_tick();
            if (one_cnt == 5'd2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL lost_two_pills_timeout: one_cnt=%0d expected to reach 2", one_cnt);
        end
        bottle_present = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sense_tick();
            if (err_code != 2'd0) break;
        end
        checks++;
        if ({err_code, one_cnt, dispense} !== {2'd3, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL bottle_lost: got err=%0d one=%0d disp=%b expected 3 2 0",
                     err_code, one_cnt, dispense);
        end
        do_stop();
        bottle_present = 1'b1;
    endtask

    task automatic test_pill_vs_timeout();
        bit hit; int nd, nc, nw;
        cfg_per_bottle = 5'd1; cfg_batch = 10'd1; bottle_present = 1'b1; pill_seen = 1'b0;
        kick_start();
        next_tick();
        next_tick();
        next_tick();
        for (int i = 1; i <= 7; i++) next_tick();
        checks++;
        if (err_code !== 2'd0) begin
            errors++;
            $display("FAIL race_no_early_jam: got err=%0d expected 0", err_code);
        end
        pill_seen = 1'b1;
        next_tick();
        pill_seen = 1'b0;
        checks++;
        if ({one_cnt, all_cnt, conveyor_adv, err_code} !== {5'd1, 10'd1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL race_pill_wins: got one=%0d all=%0d adv=%b err=%0d expected 1 1 1 0",
                     one_cnt, all_cnt, conveyor_adv, err_code);
        end
        run_to_done(10, hit, nd, nc, nw);
        checks++;
        if (!hit || nc !== 2) begin
            errors++;
            $display("FAIL race_done: got hit=%b adv_ticks_after=%0d expected 1 2", hit, nc);
        end
    endtask

    task automatic test_stop_mid_dispense();
        bit hit;
        cfg_per_bottle = 5'd4; cfg_batch = 10'd3; bottle_present = 1'b1;
        sensor_en = 1'b1; pend = 1'b0; pill_seen = 1'b0;
        kick_start();
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sense_tick();
            if (dispense && one_cnt == 5'd1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL stop_reach_dispense: second dispense not seen");
        end
        do_stop();
        checks++;
        if ({busy, dispense, one_cnt, all_cnt, err_code} !== {1'b0, 1'b0, 5'd1, 10'd0, 2'd0}) begin
            errors++;
            $display("FAIL stop_mid_dispense: got busy=%b disp=%b one=%0d all=%0d err=%0d expected 0 0 1 0 0",
                     busy, dispense, one_cnt, all_cnt, err_code);
        end
        next_tick();
        checks++;
        if ({busy, one_cnt} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL stop_stays_idle: got busy=%b one=%0d expected 0 1", busy, one_cnt);
        end
    endtask

    task automatic test_reset_mid_advance();
        bit hit;
        cfg_per_bottle = 5'd1; cfg_batch = 10'd2; bottle_present = 1'b1;
        sensor_en = 1'b1; pend = 1'b0; pill_seen = 1'b0;
        kick_start();
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sense_tick();
            if (conveyor_adv) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_reach_advance: conveyor_adv never seen");
        end
        @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dispense, conveyor_adv, busy, done, err_code, one_cnt, all_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_advance: got %h expected 0",
                     {dispense, conveyor_adv, busy, done, err_code, one_cnt, all_cnt});
        end
        sensor_en = 1'b0; pend = 1'b0; pill_seen = 1'b0;
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_restart_from_done();
        bit hit; int nd, nc, nw;
        cfg_per_bottle = 5'd2; cfg_batch = 10'd1; bottle_present = 1'b1;
        sensor_en = 1'b1; pend = 1'b0; pill_seen = 1'b0;
        kick_start();
        run_to_done(60, hit, nd, nc, nw);
        checks++;
        if (!hit || {one_cnt, all_cnt} !== {5'd2, 10'd1}) begin
            errors++;
            $display("FAIL first_done: got hit=%b one=%0d all=%0d expected 1 2 1", hit, one_cnt, all_cnt);
        end
        pend = 1'b0; pill_seen = 1'b0;
        cfg_per_bottle = 5'd1; cfg_batch = 10'd1;
        kick_start();
        checks++;
        if ({one_cnt, all_cnt, done, busy} !== {5'd0, 10'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL restart_clear: got one=%0d all=%0d done=%b busy=%b expected 0 0 0 1",
                     one_cnt, all_cnt, done, busy);
        end
        run_to_done(60, hit, nd, nc, nw);
        checks++;
        if (!hit || {done, one_cnt, all_cnt, nd} !== {1'b1, 5'd1, 10'd1, 32'd1}) begin
            errors++;
            $display("FAIL restart_done: got hit=%b done=%b one=%0d all=%0d disp=%0d expected 1 1 1 1 1",
                     hit, done, one_cnt, all_cnt, nd);
        end
        sensor_en = 1'b0; pend = 1'b0; pill_seen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_batch();
        test_cfg_fault();
        test_jam();
        test_bottle_lost();
        test_pill_vs_timeout();
        test_stop_mid_dispense();
        test_reset_mid_advance();
        test_restart_from_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
